// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, imem req/ack reads, small instruction FIFO to decode,
// branch redirect with flush and drain of an in-flight read, and stop-on-HALT.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 2,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalted} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;

    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q;

    logic push, pop, flush;

    assign inst_valid = (count_q != '0);
    assign instr      = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q] : '0;
    assign busy       = (state_q == StFetch) || (state_q == StDrain) || inst_valid;
    // A flush in the same cycle wins over a decoder pop.
    assign pop        = inst_valid && inst_ready && !flush;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        push         = 1'b0;
        flush        = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = start_pc;
                    flush   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_req = (count_q < FULL);
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                    // An unacknowledged read must complete at its original address.
                    if (imem_req && !imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = StDrain;
                    end
                end else if (imem_req && imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(1);
                    if (imem_data[31:26] == HALT_OP) begin
                        state_d = StHalted;
                    end
                end
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
            StHalted: begin
                if (start) begin
                    pc_d    = start_pc;
                    flush   = 1'b1;
                    state_d = StFetch;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    flush   = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= imem_data;
                pc_mem[wr_ptr_q]   <= pc_q;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: an imem responder and a queue-based fetch model feed a
// scoreboard; a negedge monitor checks the decode-side stream against it.
module tb_fetch_sequencer;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 2;
    localparam logic [5:0]  HALT  = 6'h3F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [31:0]   instr;
    logic [AW-1:0] inst_pc;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          busy;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .DEPTH(DEPTH), .HALT_OP(HALT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .instr      (instr),
        .inst_pc    (inst_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0]   ins;
        logic [AW-1:0] pc;
    } ent_t;

    typedef enum int {MIdle, MFetch, MDrain, MHalted} mst_t;

    ent_t          sb[$];
    int            total = 0;
    int            bad = 0;
    mst_t          mst = MIdle;
    logic [AW-1:0] mpc = '0;
    logic [AW-1:0] mdrain = '0;
    logic [31:0]   mem [256];
    bit            running = 0;
    bit            req_exp;

    // stimulus knobs
    int            lat_min, lat_max, rdy_pct, redir_pct, start_pct, halt_pct;
    bit            one_start = 0, one_redir = 0, halt_en = 0;
    logic [AW-1:0] one_start_pc, one_redir_pc, halt_addr;

    // imem responder state
    bit            pend = 0;
    int            lat_cnt = 0;
    logic [AW-1:0] pend_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int redir,
                             input int st, input int halt);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy;
        redir_pct = redir; start_pct = st; halt_pct = halt;
    endtask

    // Decode-side monitor: head entry and valid must match the model's queue.
    always @(negedge clk) begin
        if (running) begin
            chk("inst_valid", 64'(inst_valid), 64'(sb.size() != 0));
            chk("busy", 64'(busy), 64'(mst == MFetch || mst == MDrain || sb.size() != 0));
            if (sb.size() != 0) begin
                chk("instr", 64'(instr), 64'(sb[0].ins));
                chk("inst_pc", 64'(inst_pc), 64'(sb[0].pc));
                if (inst_valid && inst_ready) void'(sb.pop_front());
            end
        end
    end

    // Fetch rules applied at a clock edge to the inputs held through the cycle.
    task automatic model_update();
        ent_t e;
        if ((mst == MIdle || mst == MHalted) && start) begin
            mpc = start_pc;
            sb.delete();
            mst = MFetch;
        end else if (redirect && mst != MIdle) begin
            sb.delete();
            case (mst)
                MDrain:  if (imem_ack) mst = MFetch;
                MFetch:  if (req_exp && !imem_ack) begin mdrain = mpc; mst = MDrain; end
                MHalted: mst = MFetch;
                default: ;
            endcase
            mpc = redirect_pc;
        end else if (mst == MFetch && req_exp && imem_ack) begin
            e.ins = imem_data;
            e.pc  = mpc;
            sb.push_back(e);
            mpc = mpc + 1'b1;
            if (imem_data[31:26] == HALT) mst = MHalted;
        end else if (mst == MDrain && imem_ack) begin
            mst = MFetch;
        end
    endtask

    // Called at posedge+1: check request side, drive this cycle's inputs, advance one edge.
    task automatic cycle();
        logic [31:0] d;
        req_exp = (mst == MFetch && sb.size() < DEPTH) || mst == MDrain;
        chk("imem_req", 64'(imem_req), 64'(req_exp));
        if (req_exp) chk("imem_addr", 64'(imem_addr), 64'(mst == MDrain ? mdrain : mpc));
        imem_ack = 1'b0;
        if (imem_req) begin
            if (!pend) begin
                pend      = 1;
                pend_addr = imem_addr;
                lat_cnt   = $urandom_range(lat_max, lat_min);
            end else begin
                chk("addr_stable", 64'(imem_addr), 64'(pend_addr));
            end
            if (lat_cnt == 0) begin
                d = mem[imem_addr[7:0]];
                if ($urandom_range(99, 0) < halt_pct) d[31:26] = HALT;
                if (halt_en && imem_addr == halt_addr) d = 32'hFC00_0000;
                imem_data = d;
                imem_ack  = 1'b1;
                pend      = 0;
            end else begin
                lat_cnt--;
            end
        end
        inst_ready  = ($urandom_range(99, 0) < rdy_pct);
        start       = one_start || ($urandom_range(99, 0) < start_pct);
        start_pc    = one_start ? one_start_pc : AW'($urandom);
        redirect    = one_redir || ($urandom_range(99, 0) < redir_pct);
        redirect_pc = one_redir ? one_redir_pc : AW'($urandom);
        one_start   = 0;
        one_redir   = 0;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset landing mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        running = 0;
        rst = 1'b1;
        #1;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        sb.delete();
        mst = MIdle; mpc = '0; pend = 0;
        imem_ack = 1'b0; start = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        running = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == HALT) mem[i][31:26] = 6'h00;
        end
        set_knobs(0, 0, 100, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // back-to-back fetch from 0x10
        one_start = 1; one_start_pc = 16'h0010;
        repeat (8) cycle();

        // decoder stalled: FIFO fills, req drops, head held; then resume
        set_knobs(0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        set_knobs(0, 0, 100, 0, 0, 0);
        repeat (6) cycle();

        // redirect with same-cycle ack, then redirect during a slow read (drain)
        one_redir = 1; one_redir_pc = 16'h0020;
        cycle();
        set_knobs(3, 3, 100, 0, 0, 0);
        cycle();
        set_knobs(0, 0, 100, 0, 0, 0);
        one_redir = 1; one_redir_pc = 16'h0080;
        cycle();
        repeat (8) cycle();

        // HALT at 0x05 stops fetch; redirect resumes at 0x40
        set_knobs(0, 0, 0, 0, 0, 0);
        one_redir = 1; one_redir_pc = 16'h0002;
        halt_en = 1; halt_addr = 16'h0005;
        repeat (8) cycle();
        set_knobs(0, 0, 100, 0, 0, 0);
        repeat (4) cycle();
        halt_en = 0;
        one_redir = 1; one_redir_pc = 16'h0040;
        repeat (6) cycle();

        // PC wrap from 0xFFFE
        one_redir = 1; one_redir_pc = 16'hFFFE;
        repeat (8) cycle();

        // reset with a read outstanding, then clean restart
        set_knobs(3, 3, 0, 0, 0, 0);
        one_redir = 1; one_redir_pc = 16'h0030;
        repeat (3) cycle();
        chk("pre_rst_req", 64'(imem_req), 64'd1);
        do_reset();
        set_knobs(0, 0, 100, 0, 0, 0);
        one_start = 1; one_start_pc = 16'h0050;
        repeat (8) cycle();

        // randomized traffic
        set_knobs(0, 3, 70, 4, 3, 4);
        repeat (1500) cycle();
        do_reset();
        repeat (1500) cycle();

        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
